// File: rtl/eth_pkt_chk_if.sv
// Avalon-ST receive bus carried from the MAC RX output into the packet checker.
// Handshake: a beat transfers on a rising clk edge when valid && ready are both
// high. The source holds data/sop/eop/empty/error stable while valid is high and
// ready is low. Ready may change independently of valid.
interface eth_pkt_chk_if #(
    parameter int DATA_W  = 256,
    parameter int EMPTY_W = $clog2(DATA_W / 8)
);
    logic [DATA_W-1:0]  data;
    logic               valid;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [5:0]         error;
    logic               ready;

    modport master (output data, valid, sop, eop, empty, error, input ready);
    modport slave  (input data, valid, sop, eop, empty, error, output ready);
endinterface

// File: rtl/eth_pkt_chk.sv
// Ethernet RX packet checker: verifies DST/SRC MAC, length/EtherType and MAC
// error per packet, keeps sticky error flags and saturating statistics, detects
// SOP/EOP protocol violations and throttles the sink ready programmably.
module eth_pkt_chk #(
    parameter int DATA_W  = 256,
    parameter int EMPTY_W = $clog2(DATA_W / 8),
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_start_mon,
    input  logic             cfg_stop_mon,
    input  logic [47:0]      cfg_dst_addr,
    input  logic [47:0]      cfg_src_addr,
    input  logic [31:0]      cfg_pkt_number,
    input  logic             cfg_continuous,
    input  logic             cfg_bp_en,
    input  logic [3:0]       cfg_bp_ratio,
    output logic             stat_mon_compl,
    output logic             stat_dst_err,
    output logic             stat_src_err,
    output logic             stat_len_err,
    output logic             stat_proto_err,
    output logic [CNT_W-1:0] stat_pkt_cnt,
    output logic [CNT_W-1:0] stat_good_cnt,
    output logic [CNT_W-1:0] stat_bad_cnt,
    output logic [1:0]       dbg_state,
    eth_pkt_chk_if.slave     rx
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SOP, ST_IN_PKT, ST_CHECK} state_t;

    localparam logic [15:0] BEAT_BYTES = 16'(DATA_W / 8);

    state_t       state;
    logic [3:0]   phase;
    logic         ready_q;
    logic [47:0]  dst_q, src_q;
    logic [15:0]  len_q, byte_cnt;
    logic         err_q;
    logic [31:0]  pkt_remain;
    logic         stop_pend;

    logic               accept;
    logic [EMPTY_W-1:0] empty_bytes;
    logic [15:0]        beat_bytes;
    logic [16:0]        cnt_sum;
    logic [15:0]        cnt_next;
    logic               dst_bad, src_bad, len_bad, pkt_bad;
    logic [31:0]        remain_next;
    logic               wait_done, check_done, capture;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept      = rx.valid && ready_q;
    assign empty_bytes = rx.empty;
    assign beat_bytes  = rx.eop ? BEAT_BYTES - 16'(empty_bytes) : BEAT_BYTES;
    assign cnt_sum     = {1'b0, byte_cnt} + {1'b0, beat_bytes};
    assign cnt_next    = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    assign rx.ready    = ready_q;
    assign dbg_state   = state;

    // Per-packet verdict from the captured header and the accumulated byte count.
    always_comb begin
        dst_bad = (dst_q != cfg_dst_addr);
        src_bad = (src_q != cfg_src_addr);
        len_bad = 1'b0;
        if (len_q < 16'h0600)
            len_bad = (byte_cnt != len_q + 16'd14) || (len_q > 16'd1500) || (byte_cnt < 16'd60);
        else
            len_bad = (byte_cnt < 16'd60) || (byte_cnt > 16'd1514);
        pkt_bad = dst_bad || src_bad || len_bad || err_q;
    end

    // Completion decisions and the point where a new SOP header is captured.
    always_comb begin
        remain_next = (pkt_remain == 32'd0) ? 32'd0 : pkt_remain - 32'd1;
        wait_done   = cfg_stop_mon || stop_pend || (!cfg_continuous && pkt_remain == 32'd0);
        check_done  = cfg_stop_mon || stop_pend || (!cfg_continuous && remain_next == 32'd0);
        capture     = 1'b0;
        if (!cfg_start_mon && accept && rx.sop) begin
            case (state)
                ST_WAIT_SOP: capture = !wait_done;
                ST_IN_PKT:   capture = 1'b1;
                ST_CHECK:    capture = !check_done;
                default:     capture = 1'b0;
            endcase
        end
    end

    // Free-running phase; ready is low for the first cfg_bp_ratio phases of 16.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= 4'd0;
            ready_q <= 1'b0;
        end else begin
            phase   <= phase + 4'd1;
            ready_q <= !cfg_bp_en || (phase >= cfg_bp_ratio);
        end
    end

    // Header capture and byte accumulation for the packet in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dst_q    <= '0;
            src_q    <= '0;
            len_q    <= '0;
            byte_cnt <= '0;
            err_q    <= 1'b0;
        end else if (capture) begin
            dst_q    <= rx.data[DATA_W-1 -: 48];
            src_q    <= rx.data[DATA_W-49 -: 48];
            len_q    <= rx.data[DATA_W-97 -: 16];
            byte_cnt <= beat_bytes;
            err_q    <= rx.eop && (|rx.error);
        end else if (!cfg_start_mon && state == ST_IN_PKT && accept) begin
            byte_cnt <= cnt_next;
            if (rx.eop)
                err_q <= |rx.error;
        end
    end

    // Monitor FSM with sticky flags, statistics and completion tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            stat_mon_compl <= 1'b1;
            stat_dst_err   <= 1'b0;
            stat_src_err   <= 1'b0;
            stat_len_err   <= 1'b0;
            stat_proto_err <= 1'b0;
            stat_pkt_cnt   <= '0;
            stat_good_cnt  <= '0;
            stat_bad_cnt   <= '0;
            pkt_remain     <= '0;
            stop_pend      <= 1'b0;
        end else if (cfg_start_mon) begin
            state          <= ST_WAIT_SOP;
            stat_mon_compl <= 1'b0;
            stat_dst_err   <= 1'b0;
            stat_src_err   <= 1'b0;
            stat_len_err   <= 1'b0;
            stat_proto_err <= 1'b0;
            stat_pkt_cnt   <= '0;
            stat_good_cnt  <= '0;
            stat_bad_cnt   <= '0;
            pkt_remain     <= cfg_pkt_number;
            stop_pend      <= 1'b0;
        end else begin
            case (state)
                ST_WAIT_SOP: begin
                    if (wait_done) begin
                        stat_mon_compl <= 1'b1;
                        stop_pend      <= 1'b0;
                        state          <= ST_IDLE;
                    end else if (accept) begin
                        if (rx.sop)
                            state <= rx.eop ? ST_CHECK : ST_IN_PKT;
                        else
                            stat_proto_err <= 1'b1;
                    end
                end
                ST_IN_PKT: begin
                    if (cfg_stop_mon)
                        stop_pend <= 1'b1;
                    if (accept) begin
                        if (rx.sop) begin
                            // Missing EOP: close the old packet as bad, restart on this SOP.
                            stat_proto_err <= 1'b1;
                            stat_pkt_cnt   <= sat_inc(stat_pkt_cnt);
                            stat_bad_cnt   <= sat_inc(stat_bad_cnt);
                            pkt_remain     <= remain_next;
                            state          <= rx.eop ? ST_CHECK : ST_IN_PKT;
                        end else if (rx.eop) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    stat_dst_err <= stat_dst_err | dst_bad;
                    stat_src_err <= stat_src_err | src_bad;
                    stat_len_err <= stat_len_err | len_bad;
                    stat_pkt_cnt <= sat_inc(stat_pkt_cnt);
                    if (pkt_bad)
                        stat_bad_cnt <= sat_inc(stat_bad_cnt);
                    else
                        stat_good_cnt <= sat_inc(stat_good_cnt);
                    pkt_remain <= remain_next;
                    if (check_done) begin
                        stat_mon_compl <= 1'b1;
                        stop_pend      <= 1'b0;
                        state          <= ST_IDLE;
                    end else if (capture) begin
                        state <= rx.eop ? ST_CHECK : ST_IN_PKT;
                    end else begin
                        state <= ST_WAIT_SOP;
                        if (accept)
                            stat_proto_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_pkt_chk.sv
// Directed bench for eth_pkt_chk: a 256-bit instance with 32-bit counters and a
// 512-bit instance with 4-bit counters, sharing clock, reset and configuration.
module tb_eth_pkt_chk;
    localparam int DW_A = 256;
    localparam int DW_B = 512;
    localparam int CW_A = 32;
    localparam int CW_B = 4;
    localparam logic [47:0] CD = 48'h0011_2233_4455;
    localparam logic [47:0] CS = 48'h6677_8899_AABB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        cfg_start_mon = 1'b0, cfg_stop_mon = 1'b0;
    logic [47:0] cfg_dst_addr = CD, cfg_src_addr = CS;
    logic [31:0] cfg_pkt_number = 32'd0;
    logic        cfg_continuous = 1'b0, cfg_bp_en = 1'b0;
    logic [3:0]  cfg_bp_ratio = 4'd0;

    logic a_compl, a_dst, a_src, a_len, a_proto;
    logic [CW_A-1:0] a_pkt, a_good, a_bad;
    logic [1:0] a_state;
    logic b_compl, b_dst, b_src, b_len, b_proto;
    logic [CW_B-1:0] b_pkt, b_good, b_bad;
    logic [1:0] b_state;

    eth_pkt_chk_if #(.DATA_W(DW_A)) a_rx ();
    eth_pkt_chk_if #(.DATA_W(DW_B)) b_rx ();

    eth_pkt_chk #(.DATA_W(DW_A), .CNT_W(CW_A)) u_a (
        .clk(clk), .reset_n(reset_n),
        .cfg_start_mon(cfg_start_mon), .cfg_stop_mon(cfg_stop_mon),
        .cfg_dst_addr(cfg_dst_addr), .cfg_src_addr(cfg_src_addr),
        .cfg_pkt_number(cfg_pkt_number), .cfg_continuous(cfg_continuous),
        .cfg_bp_en(cfg_bp_en), .cfg_bp_ratio(cfg_bp_ratio),
        .stat_mon_compl(a_compl), .stat_dst_err(a_dst), .stat_src_err(a_src),
        .stat_len_err(a_len), .stat_proto_err(a_proto),
        .stat_pkt_cnt(a_pkt), .stat_good_cnt(a_good), .stat_bad_cnt(a_bad),
        .dbg_state(a_state), .rx(a_rx.slave)
    );

    eth_pkt_chk #(.DATA_W(DW_B), .CNT_W(CW_B)) u_b (
        .clk(clk), .reset_n(reset_n),
        .cfg_start_mon(cfg_start_mon), .cfg_stop_mon(cfg_stop_mon),
        .cfg_dst_addr(cfg_dst_addr), .cfg_src_addr(cfg_src_addr),
        .cfg_pkt_number(cfg_pkt_number), .cfg_continuous(cfg_continuous),
        .cfg_bp_en(cfg_bp_en), .cfg_bp_ratio(cfg_bp_ratio),
        .stat_mon_compl(b_compl), .stat_dst_err(b_dst), .stat_src_err(b_src),
        .stat_len_err(b_len), .stat_proto_err(b_proto),
        .stat_pkt_cnt(b_pkt), .stat_good_cnt(b_good), .stat_bad_cnt(b_bad),
        .dbg_state(b_state), .rx(b_rx.slave)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_stats_a(input string tag, input logic compl, dst, src, len, proto,
                                 input int pkt, good, bad);
        check({tag, "/a_compl"}, 64'(a_compl), 64'(compl));
        check({tag, "/a_dst_err"}, 64'(a_dst), 64'(dst));
        check({tag, "/a_src_err"}, 64'(a_src), 64'(src));
        check({tag, "/a_len_err"}, 64'(a_len), 64'(len));
        check({tag, "/a_proto_err"}, 64'(a_proto), 64'(proto));
        check({tag, "/a_pkt_cnt"}, 64'(a_pkt), 64'(pkt));
        check({tag, "/a_good_cnt"}, 64'(a_good), 64'(good));
        check({tag, "/a_bad_cnt"}, 64'(a_bad), 64'(bad));
    endtask

    task automatic check_stats_b(input string tag, input logic compl, dst, src, len, proto,
                                 input int pkt, good, bad);
        check({tag, "/b_compl"}, 64'(b_compl), 64'(compl));
        check({tag, "/b_dst_err"}, 64'(b_dst), 64'(dst));
        check({tag, "/b_src_err"}, 64'(b_src), 64'(src));
        check({tag, "/b_len_err"}, 64'(b_len), 64'(len));
        check({tag, "/b_proto_err"}, 64'(b_proto), 64'(proto));
        check({tag, "/b_pkt_cnt"}, 64'(b_pkt), 64'(pkt));
        check({tag, "/b_good_cnt"}, 64'(b_good), 64'(good));
        check({tag, "/b_bad_cnt"}, 64'(b_bad), 64'(bad));
    endtask

    // ---------------- driver tasks (all start and end just after a negedge) ----------------
    task automatic start_mon(input int pkts, input logic cont);
        cfg_pkt_number = 32'(pkts);
        cfg_continuous = cont;
        cfg_start_mon  = 1'b1;
        @(negedge clk);
        cfg_start_mon  = 1'b0;
    endtask

    task automatic send_beat_a(input logic [DW_A-1:0] d, input logic sop, eop,
                               input logic [4:0] empty, input logic [5:0] err);
        int guard;
        guard = 0;
        a_rx.data = d; a_rx.sop = sop; a_rx.eop = eop;
        a_rx.empty = empty; a_rx.error = err; a_rx.valid = 1'b1;
        while (!a_rx.ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!a_rx.ready) begin
            n_cmp++; n_fail++;
            $display("FAIL a_ready_wait: got ready 0 after %0d cycles, required 1", guard);
        end
        @(negedge clk);
        a_rx.valid = 1'b0; a_rx.sop = 1'b0; a_rx.eop = 1'b0; a_rx.error = 6'd0;
    endtask

    // trunc=0 sends the whole frame; otherwise only trunc beats and no EOP.
    task automatic send_frame_a(input logic [47:0] dst, src, input logic [15:0] len,
                                input int nbytes, input logic [5:0] err, input int trunc);
        int beats, nsend;
        logic [4:0] emp;
        logic [DW_A-1:0] d;
        logic last;
        beats = (nbytes + 31) / 32;
        nsend = (trunc != 0) ? trunc : beats;
        emp   = 5'(beats * 32 - nbytes);
        for (int k = 0; k < nsend; k++) begin
            d = {8{32'hC0DE_0000 | 32'(k)}};
            if (k == 0) d[DW_A-1 -: 112] = {dst, src, len};
            last = (trunc == 0) && (k == beats - 1);
            send_beat_a(d, k == 0, last, last ? emp : 5'd0, last ? err : 6'd0);
        end
    endtask

    task automatic send_frame_b(input logic [47:0] dst, src, input logic [15:0] len,
                                input logic [5:0] empty, input logic [5:0] err);
        int guard;
        logic [DW_B-1:0] d;
        guard = 0;
        d = '0;
        d[DW_B-1 -: 112] = {dst, src, len};
        b_rx.data = d; b_rx.sop = 1'b1; b_rx.eop = 1'b1;
        b_rx.empty = empty; b_rx.error = err; b_rx.valid = 1'b1;
        while (!b_rx.ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!b_rx.ready) begin
            n_cmp++; n_fail++;
            $display("FAIL b_ready_wait: got ready 0 after %0d cycles, required 1", guard);
        end
        @(negedge clk);
        b_rx.valid = 1'b0; b_rx.sop = 1'b0; b_rx.eop = 1'b0; b_rx.error = 6'd0;
    endtask

    task automatic wait_compl_a(input string tag);
        int guard;
        guard = 0;
        while (!a_compl && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!a_compl) begin
            n_cmp++; n_fail++;
            $display("FAIL %s/a_compl_wait: got 0 after %0d cycles, required 1", tag, guard);
        end
    endtask

    task automatic wait_compl_b(input string tag);
        int guard;
        guard = 0;
        while (!b_compl && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!b_compl) begin
            n_cmp++; n_fail++;
            $display("FAIL %s/b_compl_wait: got 0 after %0d cycles, required 1", tag, guard);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [47:0] dst, src;
        logic [15:0] len;
        int          nbytes;
        logic [5:0]  err;
        logic        e_dst, e_src, e_len, e_bad;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [47:0] dst, src,
                                input logic [15:0] len, input int nbytes, input logic [5:0] err,
                                input logic e_dst, e_src, e_len, e_bad);
        vec_t v;
        v.name = name; v.dst = dst; v.src = src; v.len = len; v.nbytes = nbytes; v.err = err;
        v.e_dst = e_dst; v.e_src = e_src; v.e_len = e_len; v.e_bad = e_bad;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        int ones;
        int ratios[4];

        vecs[0]  = mk("good64",    CD, CS, 16'd50,    64,   6'd0,  0, 0, 0, 0);
        vecs[1]  = mk("dst_bad",   48'h1, CS, 16'd50, 64,   6'd0,  1, 0, 0, 1);
        vecs[2]  = mk("src_bad",   CD, 48'h2, 16'd50, 64,   6'd0,  0, 1, 0, 1);
        vecs[3]  = mk("len100",    CD, CS, 16'd100,   64,   6'd0,  0, 0, 1, 1);
        vecs[4]  = mk("etype64",   CD, CS, 16'h0800,  64,   6'd0,  0, 0, 0, 0);
        vecs[5]  = mk("etype59",   CD, CS, 16'h0800,  59,   6'd0,  0, 0, 1, 1);
        vecs[6]  = mk("len46_60",  CD, CS, 16'd46,    60,   6'd0,  0, 0, 0, 0);
        vecs[7]  = mk("len1501",   CD, CS, 16'd1501,  1515, 6'd0,  0, 0, 1, 1);
        vecs[8]  = mk("len1500",   CD, CS, 16'd1500,  1514, 6'd0,  0, 0, 0, 0);
        vecs[9]  = mk("etype1515", CD, CS, 16'h0800,  1515, 6'd0,  0, 0, 1, 1);
        vecs[10] = mk("etype1514", CD, CS, 16'h0800,  1514, 6'd0,  0, 0, 0, 0);
        vecs[11] = mk("rxerr",     CD, CS, 16'd50,    64,   6'h20, 0, 0, 0, 1);
        vecs[12] = mk("etype600",  CD, CS, 16'h0600,  100,  6'd0,  0, 0, 0, 0);
        vecs[13] = mk("len5ff",    CD, CS, 16'h05FF,  100,  6'd0,  0, 0, 1, 1);

        a_rx.data = '0; a_rx.valid = 1'b0; a_rx.sop = 1'b0; a_rx.eop = 1'b0;
        a_rx.empty = '0; a_rx.error = '0;
        b_rx.data = '0; b_rx.valid = 1'b0; b_rx.sop = 1'b0; b_rx.eop = 1'b0;
        b_rx.empty = '0; b_rx.error = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_stats_a("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        check_stats_b("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        check("reset/a_ready", 64'(a_rx.ready), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table: one frame per run, exact latency of the result
        for (int i = 0; i < 14; i++) begin
            start_mon(1, 1'b0);
            send_frame_a(vecs[i].dst, vecs[i].src, vecs[i].len, vecs[i].nbytes, vecs[i].err, 0);
            check({vecs[i].name, "/compl_in_check"}, 64'(a_compl), 64'd0);
            @(negedge clk);
            check_stats_a(vecs[i].name, 1, vecs[i].e_dst, vecs[i].e_src, vecs[i].e_len, 0, 1,
                          vecs[i].e_bad ? 0 : 1, vecs[i].e_bad ? 1 : 0);
        end

        // Three back-to-back good frames
        start_mon(3, 1'b0);
        for (int i = 0; i < 3; i++) send_frame_a(CD, CS, 16'd50, 64, 6'd0, 0);
        check("three/pkt_in_check", 64'(a_pkt), 64'd2);
        check("three/compl_in_check", 64'(a_compl), 64'd0);
        @(negedge clk);
        check_stats_a("three", 1, 0, 0, 0, 0, 3, 3, 0);

        // Two bad frames in one run
        start_mon(2, 1'b0);
        send_frame_a(48'h0000_0000_0001, CS, 16'd50, 64, 6'd0, 0);
        send_frame_a(CD, CS, 16'd100, 64, 6'd0, 0);
        wait_compl_a("twobad");
        check_stats_a("twobad", 1, 1, 0, 1, 0, 2, 0, 2);

        // Missing EOP: new SOP closes the old packet as bad
        start_mon(2, 1'b0);
        send_frame_a(CD, CS, 16'd50, 64, 6'd0, 2);
        send_frame_a(CD, CS, 16'd50, 64, 6'd0, 0);
        wait_compl_a("abort");
        check_stats_a("abort", 1, 0, 0, 0, 1, 2, 1, 1);

        // Stray non-SOP beat while waiting for SOP
        start_mon(1, 1'b0);
        send_beat_a('0, 1'b0, 1'b1, 5'd0, 6'd0);
        send_frame_a(CD, CS, 16'd50, 64, 6'd0, 0);
        wait_compl_a("stray");
        check_stats_a("stray", 1, 0, 0, 0, 1, 1, 1, 0);

        // pkt_number = 0: completion on the second cycle
        start_mon(0, 1'b0);
        check("zero/compl_cycle1", 64'(a_compl), 64'd0);
        @(negedge clk);
        check("zero/compl_cycle2", 64'(a_compl), 64'd1);
        check("zero/pkt_cnt", 64'(a_pkt), 64'd0);

        // Start and stop together: start wins
        cfg_stop_mon = 1'b1;
        start_mon(1, 1'b0);
        cfg_stop_mon = 1'b0;
        repeat (3) @(negedge clk);
        check("startstop/compl", 64'(a_compl), 64'd0);
        send_frame_a(CD, CS, 16'd50, 64, 6'd0, 0);
        wait_compl_a("startstop");
        check_stats_a("startstop", 1, 0, 0, 0, 0, 1, 1, 0);

        // Restart mid-packet drops the in-flight packet uncounted
        start_mon(1, 1'b0);
        send_frame_a(48'h1, CS, 16'd50, 64, 6'd0, 1);
        start_mon(1, 1'b0);
        send_frame_a(CD, CS, 16'd50, 64, 6'd0, 0);
        wait_compl_a("restart");
        check_stats_a("restart", 1, 0, 0, 0, 0, 1, 1, 0);

        // 512-bit single-beat frames and 4-bit counter saturation
        start_mon(1, 1'b0);
        send_frame_b(CD, CS, 16'd46, 6'd4, 6'd0);
        wait_compl_b("b_single");
        check_stats_b("b_single", 1, 0, 0, 0, 0, 1, 1, 0);
        start_mon(1, 1'b0);
        send_frame_b(CD, CS, 16'd46, 6'd4, 6'h01);
        wait_compl_b("b_rxerr");
        check_stats_b("b_rxerr", 1, 0, 0, 0, 0, 1, 0, 1);
        start_mon(20, 1'b0);
        for (int i = 0; i < 20; i++) send_frame_b(CD, CS, 16'd46, 6'd4, 6'd0);
        wait_compl_b("b_sat");
        check_stats_b("b_sat", 1, 0, 0, 0, 0, 15, 15, 0);

        // Backpressure duty cycle over one full phase period
        cfg_bp_en = 1'b1;
        ratios[0] = 0; ratios[1] = 3; ratios[2] = 8; ratios[3] = 15;
        for (int r = 0; r < 4; r++) begin
            cfg_bp_ratio = 4'(ratios[r]);
            @(negedge clk);
            ones = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (a_rx.ready) ones++;
            end
            check($sformatf("bp_ratio%0d/ready_high", ratios[r]), 64'(ones), 64'(16 - ratios[r]));
        end

        // Continuous run of 100 frames under 8/16 throttling
        cfg_bp_ratio = 4'd8;
        start_mon(0, 1'b1);
        for (int i = 0; i < 100; i++) send_frame_a(CD, CS, 16'd50, 64, 6'd0, 0);
        repeat (2) @(negedge clk);
        check_stats_a("cont100", 0, 0, 0, 0, 0, 100, 100, 0);

        // Stop mid-packet completes only after that packet's check
        send_frame_a(CD, CS, 16'd50, 64, 6'd0, 1);
        cfg_stop_mon = 1'b1;
        @(negedge clk);
        cfg_stop_mon = 1'b0;
        repeat (3) @(negedge clk);
        check("stop/compl_held", 64'(a_compl), 64'd0);
        send_beat_a('0, 1'b0, 1'b1, 5'd0, 6'd0);
        check("stop/compl_in_check", 64'(a_compl), 64'd0);
        @(negedge clk);
        check_stats_a("stop", 1, 0, 0, 0, 0, 101, 101, 0);

        // Asynchronous reset mid-packet
        cfg_bp_en = 1'b0;
        start_mon(0, 1'b1);
        send_frame_a(48'h1, CS, 16'd50, 64, 6'd0, 0);
        send_frame_a(CD, CS, 16'd50, 64, 6'd0, 0);
        send_frame_a(CD, CS, 16'd50, 64, 6'd0, 1);
        check("prereset/dst_err", 64'(a_dst), 64'd1);
        check("prereset/pkt_cnt", 64'(a_pkt), 64'd2);
        #1 reset_n = 1'b0;
        #1;
        check_stats_a("async_reset", 1, 0, 0, 0, 0, 0, 0, 0);
        check("async_reset/ready", 64'(a_rx.ready), 64'd0);
        check("async_reset/state", 64'(a_state), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
